// File: rtl/lcd_pkg.sv
// Shared types and helpers for the passive-matrix LCD scan controller.
// Holds the scan state / shift phase encodings and a counter width helper.
package lcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } phase_t;

    // Bits needed for a counter running 0..n-1 (at least one bit).
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Clock-enable divider: tick is high for one clk out of every CLK_DIV.
// Ports: clk, rst_n (sync, active-low), tick (out).
module lcd_tick_gen
    import lcd_pkg::*;
#(
    parameter int CLK_DIV = 3
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = cnt_w(CLK_DIV);
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/lcd_scan_ctrl.sv
// Raw STN LCD scan controller: reads framebuffer words and drives
// FLM, LP (CL1), DCLK (CL2), M and the DW-bit data bus from one clock.
// Ports: clk, rst_n (sync, active-low); fb_rd/fb_addr out, fb_data in
// (valid 1 clk after fb_rd); frame_start pulse; lcd_flm, lcd_lp,
// lcd_dclk, lcd_m, lcd_data (MSB = leftmost pixel).
// Macro LCD_MLINE_EN: M toggles every M_LINES lines (line inversion);
// undefined, M toggles once per frame.
module lcd_scan_ctrl
    import lcd_pkg::*;
#(
    parameter int H_RES    = 240,
    parameter int V_RES    = 64,
    parameter int DW       = 4,
    parameter int AW       = 16,
    parameter int CLK_DIV  = 3,
    parameter int LP_WIDTH = 1,
    parameter int M_LINES  = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          fb_rd,
    output logic [AW-1:0] fb_addr,
    input  logic [DW-1:0] fb_data,
    output logic          frame_start,
    output logic          lcd_flm,
    output logic          lcd_lp,
    output logic          lcd_dclk,
    output logic          lcd_m,
    output logic [DW-1:0] lcd_data
);

    if (H_RES % DW != 0) begin : g_bad_hres
        $error("lcd_scan_ctrl: H_RES must be a multiple of DW");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("lcd_scan_ctrl: CLK_DIV must be at least 2");
    end
    if (LP_WIDTH < 1) begin : g_bad_lp
        $error("lcd_scan_ctrl: LP_WIDTH must be at least 1");
    end

    localparam int WPL = H_RES / DW;
    localparam int CW  = cnt_w(WPL);
    localparam int RW  = cnt_w(V_RES);
    localparam int LW  = cnt_w(2 * LP_WIDTH);

    localparam logic [CW-1:0] COL_LAST   = CW'(WPL - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(V_RES - 1);
    localparam logic [LW-1:0] LP_LAST    = LW'(2 * LP_WIDTH - 1);
    localparam logic [LW-1:0] LP_ON_LAST = LW'(LP_WIDTH - 1);

    logic tick;

    lcd_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    state_t        state, state_nx;
    phase_t        phase, phase_nx;
    logic [CW-1:0] col, col_nx;
    logic [RW-1:0] row, row_nx;
    logic [LW-1:0] lpcnt, lpcnt_nx;
    logic [AW-1:0] addr_nx;
    logic          rd_nx;
    logic          fs_nx;
    logic          flm_nx;
    logic          lp_nx;
    logic          dclk_nx;
    logic          m_nx;
    logic [DW-1:0] data_nx;

    logic          rd_d;
    logic [DW-1:0] cap;
    logic [DW-1:0] word;
    logic          wrap;

`ifdef LCD_MLINE_EN
    localparam int MW = cnt_w(M_LINES);
    localparam logic [MW-1:0] M_LAST = MW'(M_LINES - 1);
    // A partial group at the bottom of the frame still flips M at wrap.
    localparam bit M_WRAP_FLIP = (V_RES % M_LINES) != 0;

    logic [MW-1:0] mcnt, mcnt_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcnt <= '0;
        end else begin
            mcnt <= mcnt_nx;
        end
    end
`endif

    // Read data lands one clk after fb_rd; when that clk is also the
    // phase-A tick the word is taken straight from the bus.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_d <= 1'b0;
            cap  <= '0;
        end else begin
            rd_d <= fb_rd;
            if (rd_d) begin
                cap <= fb_data;
            end
        end
    end

    assign word = rd_d ? fb_data : cap;
    assign wrap = (row == ROW_LAST);

    always_comb begin
        state_nx = state;
        phase_nx = phase;
        col_nx   = col;
        row_nx   = row;
        lpcnt_nx = lpcnt;
        addr_nx  = fb_addr;
        rd_nx    = 1'b0;
        fs_nx    = 1'b0;
        flm_nx   = lcd_flm;
        lp_nx    = lcd_lp;
        dclk_nx  = lcd_dclk;
        m_nx     = lcd_m;
        data_nx  = lcd_data;
`ifdef LCD_MLINE_EN
        mcnt_nx  = mcnt;
`endif
        if (tick) begin
            unique case (state)
                IDLE: begin
                    state_nx = SHIFT;
                    phase_nx = PH_A;
                    addr_nx  = '0;
                    rd_nx    = 1'b1;
                end
                SHIFT: begin
                    if (phase == PH_A) begin
                        dclk_nx  = 1'b1;
                        data_nx  = word;
                        phase_nx = PH_B;
                    end else begin
                        dclk_nx = 1'b0;
                        if (col != COL_LAST) begin
                            col_nx   = col + CW'(1);
                            addr_nx  = fb_addr + AW'(1);
                            rd_nx    = 1'b1;
                            phase_nx = PH_A;
                        end else begin
                            col_nx   = '0;
                            state_nx = LATCH;
                            lpcnt_nx = '0;
                            lp_nx    = 1'b1;
                            flm_nx   = wrap;
                        end
                    end
                end
                LATCH: begin
                    if (lpcnt == LP_LAST) begin
                        lp_nx    = 1'b0;
                        flm_nx   = 1'b0;
                        state_nx = SHIFT;
                        phase_nx = PH_A;
                        rd_nx    = 1'b1;
                        if (wrap) begin
                            row_nx  = '0;
                            addr_nx = '0;
                            fs_nx   = 1'b1;
                        end else begin
                            row_nx  = row + RW'(1);
                            addr_nx = fb_addr + AW'(1);
                        end
`ifdef LCD_MLINE_EN
                        if (wrap) begin
                            mcnt_nx = '0;
                            if (mcnt == M_LAST || M_WRAP_FLIP) begin
                                m_nx = ~lcd_m;
                            end
                        end else if (mcnt == M_LAST) begin
                            mcnt_nx = '0;
                            m_nx    = ~lcd_m;
                        end else begin
                            mcnt_nx = mcnt + MW'(1);
                        end
`else
                        if (wrap) begin
                            m_nx = ~lcd_m;
                        end
`endif
                    end else begin
                        lpcnt_nx = lpcnt + LW'(1);
                        lp_nx    = (lpcnt < LP_ON_LAST);
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            phase       <= PH_A;
            col         <= '0;
            row         <= '0;
            lpcnt       <= '0;
            fb_rd       <= 1'b0;
            fb_addr     <= '0;
            frame_start <= 1'b0;
            lcd_flm     <= 1'b0;
            lcd_lp      <= 1'b0;
            lcd_dclk    <= 1'b0;
            lcd_m       <= 1'b0;
            lcd_data    <= '0;
        end else begin
            state       <= state_nx;
            phase       <= phase_nx;
            col         <= col_nx;
            row         <= row_nx;
            lpcnt       <= lpcnt_nx;
            fb_rd       <= rd_nx;
            fb_addr     <= addr_nx;
            frame_start <= fs_nx;
            lcd_flm     <= flm_nx;
            lcd_lp      <= lp_nx;
            lcd_dclk    <= dclk_nx;
            lcd_m       <= m_nx;
            lcd_data    <= data_nx;
        end
    end

endmodule

// File: tb/tb_lcd_scan_ctrl.sv
// Bench for lcd_scan_ctrl: 8x4 panel, DW=4, at CLK_DIV=2 and CLK_DIV=5.
// Framebuffer model returns the low address bits one clk after fb_rd.
module tb_lcd_scan_ctrl;

    localparam int NCYC  = 240;
    localparam int RST_K = 172;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic        fb_rd, frame_start, lcd_flm, lcd_lp, lcd_dclk, lcd_m;
    logic [15:0] fb_addr;
    logic [3:0]  fb_data = '0;
    logic [3:0]  lcd_data;

    logic        fb_rd5, frame_start5, lcd_flm5, lcd_lp5, lcd_dclk5, lcd_m5;
    logic [15:0] fb_addr5;
    logic [3:0]  fb_data5 = '0;
    logic [3:0]  lcd_data5;

    lcd_scan_ctrl #(
        .H_RES(8), .V_RES(4), .DW(4), .AW(16),
        .CLK_DIV(2), .LP_WIDTH(1), .M_LINES(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fb_rd(fb_rd), .fb_addr(fb_addr), .fb_data(fb_data),
        .frame_start(frame_start), .lcd_flm(lcd_flm), .lcd_lp(lcd_lp),
        .lcd_dclk(lcd_dclk), .lcd_m(lcd_m), .lcd_data(lcd_data)
    );

    lcd_scan_ctrl #(
        .H_RES(8), .V_RES(4), .DW(4), .AW(16),
        .CLK_DIV(5), .LP_WIDTH(1), .M_LINES(3)
    ) u_dut5 (
        .clk(clk), .rst_n(rst_n),
        .fb_rd(fb_rd5), .fb_addr(fb_addr5), .fb_data(fb_data5),
        .frame_start(frame_start5), .lcd_flm(lcd_flm5), .lcd_lp(lcd_lp5),
        .lcd_dclk(lcd_dclk5), .lcd_m(lcd_m5), .lcd_data(lcd_data5)
    );

    always @(posedge clk) begin
        if (fb_rd)  fb_data  <= fb_addr[3:0];
        if (fb_rd5) fb_data5 <= fb_addr5[3:0];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, want);
        end
    endtask

    int r_rd[NCYC], r_addr[NCYC], r_dclk[NCYC], r_lp[NCYC];
    int r_flm[NCYC], r_m[NCYC], r_fs[NCYC], r_data[NCYC], r_vec[NCYC];
    int s_rd[NCYC], s_dclk[NCYC], s_lp[NCYC], s_data[NCYC], s_vec[NCYC];

    initial begin
        int n, first, prev, hi, lo, j, m_pre;
        int exp_tog[$];
`ifdef LCD_MLINE_EN
        exp_tog = '{37, 49, 85, 97, 133, 145};
        m_pre   = 0;
`else
        exp_tog = '{49, 97, 145};
        m_pre   = 1;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out", int'({fb_rd, frame_start, lcd_flm, lcd_lp,
                             lcd_dclk, lcd_m, fb_addr, lcd_data}), 0);
        chk("rst_out5", int'({fb_rd5, frame_start5, lcd_flm5, lcd_lp5,
                              lcd_dclk5, lcd_m5, fb_addr5, lcd_data5}), 0);

        rst_n = 1'b1;
        for (int k = 0; k < NCYC; k++) begin
            @(negedge clk);
            r_rd[k]   = int'(fb_rd);
            r_addr[k] = int'(fb_addr);
            r_dclk[k] = int'(lcd_dclk);
            r_lp[k]   = int'(lcd_lp);
            r_flm[k]  = int'(lcd_flm);
            r_m[k]    = int'(lcd_m);
            r_fs[k]   = int'(frame_start);
            r_data[k] = int'(lcd_data);
            r_vec[k]  = int'({fb_rd, frame_start, lcd_flm, lcd_lp,
                              lcd_dclk, lcd_m, fb_addr, lcd_data});
            s_rd[k]   = int'(fb_rd5);
            s_dclk[k] = int'(lcd_dclk5);
            s_lp[k]   = int'(lcd_lp5);
            s_data[k] = int'(lcd_data5);
            s_vec[k]  = int'({fb_rd5, frame_start5, lcd_flm5, lcd_lp5,
                              lcd_dclk5, lcd_m5, fb_addr5, lcd_data5});
            if (k == RST_K)     rst_n = 1'b0;
            if (k == RST_K + 1) rst_n = 1'b1;
        end

        // CLK_DIV=2: reads, addresses and 1-clk strobe width
        n = 0;
        first = -1;
        for (int k = 0; k <= RST_K; k++) begin
            if (r_rd[k] != 0) begin
                if (first < 0) first = k;
                chk("rd_addr", r_addr[k], n % 8);
                chk("rd_width", r_rd[k+1], 0);
                n++;
            end
        end
        chk("rd_first", first, 1);
        chk("rd_count", n, 29);

        // data presented on each dclk rise
        n = 0;
        first = -1;
        for (int k = 1; k <= RST_K; k++) begin
            if (r_dclk[k] != 0 && r_dclk[k-1] == 0) begin
                if (first < 0) first = k;
                chk("dclk_data", r_data[k], n % 8);
                n++;
            end
        end
        chk("dclk_first", first, 3);
        chk("dclk_count", n, 29);
        hi = 0;
        j = 3;
        while (j < NCYC && r_dclk[j] != 0) begin hi++; j++; end
        chk("dclk_hi", hi, 2);

        // line latch pulses and line period
        n = 0;
        prev = -1;
        for (int k = 1; k <= RST_K; k++) begin
            if (r_lp[k] != 0 && r_lp[k-1] == 0) begin
                if (prev < 0) chk("lp_first", k, 9);
                else          chk("line_per", k - prev, 12);
                prev = k;
                n++;
            end
        end
        chk("lp_count", n, 14);
        hi = 0;
        j = 9;
        while (j < NCYC && r_lp[j] != 0) begin hi++; j++; end
        chk("lp_hi", hi, 2);

        // frame boundaries
        n = 0;
        for (int k = 0; k <= RST_K; k++) begin
            if (r_fs[k] != 0) begin
                if (n < 3) chk("fs_at", k, 49 + 48 * n);
                n++;
            end
        end
        chk("fs_count", n, 3);

        n = 0;
        for (int k = 0; k <= RST_K; k++) n += r_flm[k];
        chk("flm_count", n, 12);
        chk("flm_edges", r_flm[44] * 8 + r_flm[45] * 4 + r_flm[48] * 2 + r_flm[49], 6);

        n = 0;
        for (int k = 1; k <= RST_K; k++) begin
            if (r_m[k] != r_m[k-1]) begin
                if (n < exp_tog.size()) chk("m_tog_at", k, exp_tog[n]);
                n++;
            end
        end
        chk("m_tog_count", n, exp_tog.size());

        // reset in the middle of a row-2 shift
        chk("pre_rst_dclk", r_dclk[RST_K], 1);
        chk("pre_rst_m", r_m[RST_K], m_pre);
        chk("pre_rst_addr", r_addr[RST_K], 4);
        chk("mid_rst_out", r_vec[RST_K+1], 0);
        chk("mid_rst_out5", s_vec[RST_K+1], 0);
        first = -1;
        for (int k = RST_K + 1; k < NCYC; k++) begin
            if (r_rd[k] != 0 && first < 0) first = k;
        end
        chk("rs_rd_first", first, RST_K + 3);
        chk("rs_addr", r_addr[RST_K+3], 0);
        chk("rs_m", r_m[RST_K+3], 0);
        chk("rs_data", r_data[RST_K+5], 0);
        n = 0;
        first = -1;
        for (int k = RST_K + 1; k < NCYC; k++) begin
            if (r_fs[k] != 0) begin n++; first = k; end
        end
        chk("rs_fs_at", first, RST_K + 51);
        chk("rs_fs_count", n, 1);

        // CLK_DIV=5 instance
        first = -1;
        n = 0;
        for (int k = 0; k <= RST_K; k++) begin
            if (s_rd[k] != 0) begin
                if (first < 0) first = k;
                if (s_rd[k+1] != 0) n++;
            end
        end
        chk("d5_rd_first", first, 4);
        chk("d5_rd_wide", n, 0);

        first = -1;
        n = 0;
        for (int k = 1; k <= RST_K; k++) begin
            if (s_dclk[k] != 0 && s_dclk[k-1] == 0) begin
                if (first < 0) first = k;
                chk("d5_data", s_data[k], n % 8);
                n++;
            end
        end
        chk("d5_rise", first, 9);
        hi = 0;
        lo = 0;
        j = 9;
        while (j < NCYC && s_dclk[j] != 0) begin hi++; j++; end
        while (j < NCYC && s_dclk[j] == 0) begin lo++; j++; end
        chk("d5_hi", hi, 5);
        chk("d5_lo", lo, 5);

        first = -1;
        prev = -1;
        for (int k = 1; k <= RST_K; k++) begin
            if (s_lp[k] != 0 && s_lp[k-1] == 0) begin
                if (first < 0) first = k;
                else if (prev < 0) prev = k;
            end
        end
        chk("d5_lp_first", first, 24);
        chk("d5_line_per", prev - first, 30);
        hi = 0;
        j = 24;
        while (j < NCYC && s_lp[j] != 0) begin hi++; j++; end
        chk("d5_lp_hi", hi, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_scan_ctrl.md
Name: lcd_scan_ctrl

Overview:
- Parametrised raw passive-matrix (STN) LCD scan controller. Drives FLM, CL1/LP, CL2/DCLK, M and a DW-bit data bus.
- Replaces the fabric-divided LCD clock with a single-clock design that uses an internal clock-enable tick.
- Sits between the framebuffer read port and the LCD pins. Panel geometry, bus width, timing and M-inversion are all parametrised.
- Adds a frame_start strobe so the framebuffer owner can swap buffers.

Parameters:
- H_RES, 240, pixels per line; must be divisible by DW.
- V_RES, 64, lines per frame.
- DW, 4, LCD data bus width and framebuffer word width.
- AW, 16, framebuffer address width; must satisfy 2^AW >= V_RES*H_RES/DW.
- CLK_DIV, 3, clk cycles per tick. Minimum 2. One DCLK period = 2 ticks.
- LP_WIDTH, 1, ticks that LP is high. LP is followed by LP_WIDTH ticks of hold-low.
- M_LINES, 13, lines per M toggle; used only with LCD_MLINE_EN.

Ports:
- clk  in  1  system clock; only clock domain.
- rst_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
- fb_rd  out  1  one-clk read strobe to the framebuffer.
- fb_addr  out  AW  framebuffer word address.
- fb_data  in  DW  read data; valid exactly 1 clk after fb_rd.
- frame_start  out  1  one-clk pulse when row wraps to 0.
- lcd_flm  out  1  first-line marker.
- lcd_lp  out  1  line latch pulse (CL1).
- lcd_dclk  out  1  data shift clock (CL2).
- lcd_m  out  1  AC-drive alternation signal.
- lcd_data  out  DW  pixel data; MSB is the leftmost pixel.

Behaviour:
- Reset (rst_n=0 at a clk edge): on the next edge, all outputs are 0, all counters are 0, state = IDLE. This holds mid-line and mid-frame; no partial-line completion.
- Tick: a divider counts 0..CLK_DIV-1. tick=1 when the count is CLK_DIV-1. All state changes occur on tick except fb_data capture.
- Derived values: WPL = H_RES/DW words per line. Counters: col 0..WPL-1, row 0..V_RES-1, lpcnt 0..2*LP_WIDTH-1.
- IDLE: on the first tick, go to SHIFT with phase=A, and pulse fb_rd with fb_addr = row*WPL + col.
- SHIFT, phase A tick:
  - lcd_dclk<=1.
  - lcd_data <= the word captured from fb_data 1 clk after the last fb_rd.
  - phase<=B.
- SHIFT, phase B tick:
  - lcd_dclk<=0; the panel samples on this falling edge.
  - If col<WPL-1: col++, pulse fb_rd for the next address, phase<=A.
  - Else: col<=0, go to LATCH, lpcnt<=0.
- LATCH:
  - lcd_lp=1 while lpcnt<LP_WIDTH, else 0. lcd_dclk stays 0; lcd_data holds.
  - lcd_flm=1 for the whole LATCH when row==V_RES-1, else 0.
  - On the tick where lpcnt==2*LP_WIDTH-1:
    - row wraps to 0 after V_RES-1; on wrap, frame_start pulses for 1 clk and lcd_m toggles (default mode).
    - Go to SHIFT phase A, and pulse fb_rd on the same clk for the new row's word 0.
- Timing: line period = (2*WPL + 2*LP_WIDTH)*CLK_DIV clk. Frame period = V_RES * line period.
- fb_addr: holds its value between reads. Wraps to 0 together with row; never exceeds V_RES*WPL-1.
- fb_data latency: fixed at 1 clk. CLK_DIV>=2 guarantees capture before the next phase-A tick.
- Illegal parameters (H_RES%DW!=0, CLK_DIV<2, LP_WIDTH<1): elaboration-time error.

Optional Feature:
- Macro: LCD_MLINE_EN.
- Defined: lcd_m toggles at the end of every M_LINES-th LATCH (line-inversion mode). The M line counter resets to 0 on frame wrap, and M also toggles at frame wrap if V_RES%M_LINES!=0.
- Undefined: lcd_m toggles only at frame wrap, and the M_LINES parameter is ignored.

Decomposition:
- Package lcd_pkg:
  - state encoding IDLE/SHIFT/LATCH, phase A/B.
  - Width helper function clog2-based for col/row/lpcnt widths.
- One sub-module: lcd_tick_gen (CLK_DIV clock-enable divider, synchronous active-low reset, output tick).

Test Plan:
- Shared setup: H_RES=8, V_RES=4, DW=4, CLK_DIV=2, LP_WIDTH=1. Framebuffer model returns fb_data = fb_addr[3:0] 1 clk after fb_rd.
- Reset release -> line period 12 clk, frame period 48 clk. lcd_data sequence per dclk rise: 0,1 | 2,3 | 4,5 | 6,7. fb_addr wraps 7->0.
- Frame boundary -> flm high only during row-3 LATCH (4 clk). frame_start is a 1-clk pulse at wrap. lcd_m toggles once every 48 clk.
- Assert rst_n=0 mid-SHIFT of row 2 for 1 clk -> next clk all outputs 0. Restart from addr 0 with lcd_m=0.
- CLK_DIV=5 -> dclk high/low each exactly 5 clk; lp high exactly 5 clk; fb_rd remains 1 clk wide.
- With LCD_MLINE_EN, M_LINES=3, V_RES=4 -> lcd_m toggles after line 2 and at frame wrap. Check the toggle pattern over 2 frames.
